// File: rtl/pipe_control.sv
// Pipeline control for a 5-stage ARM-subset core: ID decode, EX/MEM/WB control
// pipe, load-use stall with a multi-cycle bubble counter, illegal-opcode counter.
module pipe_control #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZREG     = 31,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LU_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       opcode,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              id_stall,
  output logic [17:0]       ex_ctrl,
  output logic [17:0]       mem_ctrl,
  output logic [17:0]       wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int unsigned CW  = 18;
  localparam int unsigned SCW = 2;

  localparam int unsigned B_UNCOND  = 0;
  localparam int unsigned B_BRANCH  = 1;
  localparam int unsigned B_BRREG   = 2;
  localparam int unsigned B_BRLINK  = 3;
  localparam int unsigned B_MEMRD   = 4;
  localparam int unsigned B_REG2LOC = 5;
  localparam int unsigned B_ALUSRC  = 6;
  localparam int unsigned B_REGWR   = 7;
  localparam int unsigned B_IMM     = 9;
  localparam int unsigned B_MEM2REG = 10;
  localparam int unsigned B_MEMWR   = 11;
  localparam int unsigned B_ALUON   = 13;
  localparam int unsigned B_SETFL   = 14;
  localparam int unsigned B_ILLEGAL = 15;
  localparam int unsigned B_FWD0    = 16;
  localparam int unsigned B_FWD1    = 17;

  localparam logic [REG_AW-1:0] ZR        = REG_AW'(ZREG);
  localparam logic [SCW-1:0]    STALL_RLD = SCW'(LU_STALL - 1);

  logic [CW-1:0]     ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
  logic              ex_valid_q, ex_valid_d, mem_valid_q, wb_valid_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic [SCW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  logic [CW-1:0] dec_ctrl;
  logic          uses_rs1, uses_rs2;
  logic          hazard, stall_now, issue;

  // Priority decode; an X opcode falls through every compare to illegal.
  always_comb begin
    dec_ctrl = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (opcode[10:5] == 6'b000101) begin
      dec_ctrl[B_UNCOND] = 1'b1;
    end else if (opcode[10:3] == 8'b01010100) begin
      dec_ctrl[B_BRANCH] = 1'b1;
      dec_ctrl[B_ALUON]  = 1'b1;
    end else if (opcode[10:5] == 6'b100101) begin
      dec_ctrl[B_UNCOND] = 1'b1;
      dec_ctrl[B_BRANCH] = 1'b1;
      dec_ctrl[B_BRLINK] = 1'b1;
      dec_ctrl[B_REGWR]  = 1'b1;
      dec_ctrl[B_ALUON]  = 1'b1;
    end else if (opcode == 11'b11010110000) begin
      dec_ctrl[B_BRREG] = 1'b1;
      dec_ctrl[B_ALUON] = 1'b1;
      uses_rs1          = 1'b1;
    end else if (opcode[10:3] == 8'b10110100) begin
      dec_ctrl[B_BRANCH] = 1'b1;
      dec_ctrl[B_ALUON]  = 1'b1;
      dec_ctrl[B_SETFL]  = 1'b1;
      uses_rs2           = 1'b1;
    end else if (opcode[10:1] == 10'b1001000100) begin
      dec_ctrl[B_ALUSRC] = 1'b1;
      dec_ctrl[B_REGWR]  = 1'b1;
      dec_ctrl[B_IMM]    = 1'b1;
      dec_ctrl[B_ALUON]  = 1'b1;
      dec_ctrl[B_FWD1]   = 1'b1;
      uses_rs1           = 1'b1;
    end else if ((opcode == 11'b10101011000) || (opcode == 11'b11101011000)) begin
      dec_ctrl[B_REG2LOC] = 1'b1;
      dec_ctrl[B_REGWR]   = 1'b1;
      dec_ctrl[B_ALUON]   = 1'b1;
      dec_ctrl[B_SETFL]   = 1'b1;
      dec_ctrl[B_FWD0]    = 1'b1;
      dec_ctrl[B_FWD1]    = 1'b1;
      uses_rs1            = 1'b1;
      uses_rs2            = 1'b1;
    end else if (opcode == 11'b11111000010) begin
      dec_ctrl[B_MEMRD]   = 1'b1;
      dec_ctrl[B_ALUSRC]  = 1'b1;
      dec_ctrl[B_REGWR]   = 1'b1;
      dec_ctrl[B_MEM2REG] = 1'b1;
      dec_ctrl[B_ALUON]   = 1'b1;
      uses_rs1            = 1'b1;
    end else if (opcode == 11'b11111000000) begin
      dec_ctrl[B_ALUSRC] = 1'b1;
      dec_ctrl[B_MEMWR]  = 1'b1;
      dec_ctrl[B_ALUON]  = 1'b1;
      uses_rs1           = 1'b1;
      uses_rs2           = 1'b1;
    end else begin
      dec_ctrl[B_ILLEGAL] = 1'b1;
    end
  end

  // Load in EX whose destination the ID instruction reads; the zero register never hazards.
  always_comb begin
    hazard = id_valid && ex_valid_q && ex_ctrl_q[B_MEMRD] && (ex_rd_q != ZR) &&
             ((uses_rs1 && (id_rs1 == ex_rd_q)) || (uses_rs2 && (id_rs2 == ex_rd_q)));
  end

  // While the counter runs the hazard is not re-checked; flush overrides everything.
  always_comb begin
    stall_now   = !flush && ((stall_cnt_q != '0) || hazard);
    issue       = id_valid && !flush && !stall_now;
    stall_cnt_d = '0;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != '0) begin
      stall_cnt_d = stall_cnt_q - SCW'(1);
    end else if (hazard) begin
      stall_cnt_d = STALL_RLD;
    end
  end

  always_comb begin
    ex_ctrl_d     = '0;
    ex_valid_d    = 1'b0;
    ex_rd_d       = ZR;
    illegal_cnt_d = illegal_cnt_q;
    if (issue) begin
      ex_ctrl_d  = dec_ctrl;
      ex_valid_d = 1'b1;
      ex_rd_d    = id_rd;
      if (dec_ctrl[B_ILLEGAL] && (illegal_cnt_q != '1)) begin
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q     <= '0;
      mem_ctrl_q    <= '0;
      wb_ctrl_q     <= '0;
      ex_valid_q    <= 1'b0;
      mem_valid_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      ex_rd_q       <= ZR;
      mem_rd_q      <= ZR;
      wb_rd_q       <= ZR;
      stall_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      mem_ctrl_q    <= ex_ctrl_q;
      mem_valid_q   <= ex_valid_q;
      mem_rd_q      <= ex_rd_q;
      wb_ctrl_q     <= mem_ctrl_q;
      wb_valid_q    <= mem_valid_q;
      wb_rd_q       <= mem_rd_q;
      stall_cnt_q   <= stall_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign id_stall    = stall_now && !rst;
  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign ex_valid    = ex_valid_q;
  assign mem_valid   = mem_valid_q;
  assign wb_valid    = wb_valid_q;
  assign ex_rd       = ex_rd_q;
  assign mem_rd      = mem_rd_q;
  assign wb_rd       = wb_rd_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter REG_AW, default 5, register-index width.
REQ-002 Parameter ZREG, default 31, zero-register index; never a hazard source.
REQ-003 Parameter CNT_W, default 8, illegal-opcode counter width.
REQ-004 Parameter LU_STALL, default 1 (range 1..3), bubble cycles inserted per load-use hazard.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 opcode  input  11  ID-stage instruction bits [31:21].
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_rs1, id_rs2, id_rd  input  REG_AW each  ID-stage register indices.
REQ-010 flush  input  1  branch taken; squash the ID instruction.
REQ-011 id_stall  output  1  hold PC and IF/ID this cycle.
REQ-012 ex_ctrl, mem_ctrl, wb_ctrl  output  18 each  registered control word per stage.
REQ-013 ex_valid, mem_valid, wb_valid  output  1 each  stage holds a real instruction.
REQ-014 ex_rd, mem_rd, wb_rd  output  REG_AW each  destination index per stage.
REQ-015 illegal_cnt  output  CNT_W  saturating count of illegal opcodes issued.

Function
REQ-016 Control word bits: 0 uncondBr, 1 branch, 2 branchReg, 3 branchLink, 4 memRead, 5 Reg2Loc, 6 ALU_Src, 7 RegWrite, 8 ALU_SH, 9 Imm, 10 memToReg, 11 memWrite, 12 shiftDirn, 13 ALU_on, 14 set_flags, 15 illegal, 17:16 fwdEn.
REQ-017 Decode is combinational and X/Z-free; every bit not listed is 0.
REQ-018 B (op[10:5]=000101): uncondBr.
REQ-019 B.cond (op[10:3]=01010100): branch, ALU_on.
REQ-020 BL (op[10:5]=100101): uncondBr, branch, branchLink, RegWrite, ALU_on.
REQ-021 BR (op=11010110000): branchReg, ALU_on; reads rs1.
REQ-022 CBZ (op[10:3]=10110100): branch, ALU_on, set_flags; reads rs2.
REQ-023 ADDI (op[10:1]=1001000100): ALU_Src, RegWrite, Imm, ALU_on, fwdEn=10; reads rs1.
REQ-024 ADDS (10101011000) / SUBS (11101011000): Reg2Loc, RegWrite, ALU_on, set_flags, fwdEn=11; read rs1, rs2.
REQ-025 LDUR (11111000010): memRead, ALU_Src, RegWrite, memToReg, ALU_on; reads rs1.
REQ-026 STUR (11111000000): ALU_Src, memWrite, ALU_on; reads rs1, rs2.
REQ-027 Priority order is REQ-018 to REQ-026 as listed; any other opcode: illegal=1 only.
REQ-028 Each cycle without stall: EX<=ID decode, MEM<=EX, WB<=MEM (ctrl, valid, rd); latency ID->WB is 3 cycles.
REQ-029 Bubble = ctrl 0, valid 0, rd ZREG.
REQ-030 id_valid=0: ID is a bubble; it never raises a hazard or counts as illegal.
REQ-031 Load-use hazard: ex_valid & ex_ctrl[4] & ex_rd!=ZREG & ex_rd matches a register the ID instruction reads.
REQ-032 On hazard: id_stall=1; bubble into EX; MEM/WB advance; stall persists for LU_STALL consecutive cycles, tracked by a counter; the hazard is not re-evaluated until the counter expires.
REQ-033 flush=1: bubble into EX; id_stall=0; cancels any stall in progress (counter cleared).
REQ-034 flush and hazard in the same cycle: flush wins.
REQ-035 illegal_cnt increments once per illegal instruction entering EX; saturates at all-ones; never increments for stalled repeats or flushed instructions.

Reset
REQ-036 While rst=1: all stage ctrl=0, valid=0, rd=ZREG, id_stall=0, stall counter=0, illegal_cnt=0; reset asserted mid-stall aborts the stall immediately.
REQ-037 First rising edge after rst falls loads EX normally.

Verification
REQ-038 ADDS, op=10101011000, id_valid=1 -> next cycle ex_ctrl=0x360A0, ex_valid=1; same word in wb_ctrl 2 cycles later.
REQ-039 LDUR rd=3, then ADDS rs2=3, LU_STALL=1 -> id_stall=1 for 1 cycle, EX bubble, ADDS reaches EX one cycle late.
REQ-040 LDUR rd=31, then consumer of reg 31 -> id_stall stays 0.
REQ-041 Load-use hazard with flush=1 in the same cycle -> id_stall=0, ex_valid=0 next cycle.
REQ-042 Opcode 11111111111 issued 300 times, CNT_W=8 -> ex_ctrl=0x08000, illegal_cnt saturates at 255.
REQ-043 rst pulsed during a LU_STALL=3 stall -> all outputs are reset values immediately; no residual stall after release.
